gcd_ctrl: RTL and testbench

//  Control FSM for the 8-bit subtractive GCD datapath dp. It accepts two operands over one

---
 rtl/gcd_pkg.sv | 29 ++
 rtl/gcd_ctrl.sv | 125 ++++++++++++
 tb/tb_gcd_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the subtractive GCD controller: FSM state encoding and the
// bundle of dp control lines with its idle (hold everything) value.
package gcd_pkg;

   typedef enum logic [1:0] {
      S_LOAD_X = 2'd0,
      S_LOAD_Y = 2'd1,
      S_CALC   = 2'd2,
      S_DONE   = 2'd3
   } gcd_state_t;

   typedef struct packed {
      logic xhold;
      logic xload;
      logic yhold;
      logic yload;
   } dp_ctrl_t;

   localparam logic DP_HOLD_DFLT = 1'b1;
   localparam logic DP_LOAD_DFLT = 1'b0;

   localparam dp_ctrl_t DP_CTRL_IDLE = '{
      xhold: DP_HOLD_DFLT,
      xload: DP_LOAD_DFLT,
      yhold: DP_HOLD_DFLT,
      yload: DP_LOAD_DFLT
   };

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the 8-bit subtractive GCD datapath: loads x then y from the
// shared din bus, steers subtractions until x==y or the step budget runs out.
module gcd_ctrl
   import gcd_pkg::*;
#(
   parameter int ITER_W   = 8,
   parameter int MAX_ITER = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              x_eq_y,
   input  logic              x_gt_y,
   output logic              xhold,
   output logic              xload,
   output logic              yhold,
   output logic              yload,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              err,
   output logic [ITER_W-1:0] iter_cnt,
   output gcd_state_t        o_dbg_state
);

   localparam logic [ITER_W-1:0] LP_MAX_ITER = ITER_W'(MAX_ITER);

   gcd_state_t        r_state;
   logic [ITER_W-1:0] r_iter;
   logic              r_err;

   gcd_state_t        w_state_nxt;
   logic [ITER_W-1:0] w_iter_nxt;
   logic              w_err_nxt;
   dp_ctrl_t          w_ctrl;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_LOAD_X;
         r_iter  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_iter  <= w_iter_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Both handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; ready depends only on state, never on the partner's valid.
   always_comb begin
      w_state_nxt = r_state;
      w_iter_nxt  = r_iter;
      w_err_nxt   = r_err;
      w_ctrl      = DP_CTRL_IDLE;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;

      case (r_state)
         S_LOAD_X: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_ctrl.xhold = 1'b0;
               w_state_nxt  = S_LOAD_Y;
            end
         end

         S_LOAD_Y: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (in_valid) begin
               w_ctrl.yhold = 1'b0;
               w_iter_nxt   = '0;
               w_err_nxt    = 1'b0;
               w_state_nxt  = S_CALC;
            end
         end

         S_CALC: begin
            w_busy = 1'b1;
            // Budget check precedes any step so iter_cnt stops at MAX_ITER.
            if (x_eq_y) begin
               w_state_nxt = S_DONE;
            end else if (r_iter == LP_MAX_ITER) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (x_gt_y) begin
               w_ctrl.xload = 1'b1;
               w_iter_nxt   = r_iter + 1'b1;
            end else begin
               w_ctrl.yload = 1'b1;
               w_iter_nxt   = r_iter + 1'b1;
            end
         end

         S_DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_LOAD_X;
            end
         end

         default: begin
            w_state_nxt = S_LOAD_X;
         end
      endcase
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = w_out_valid;
   assign busy        = w_busy;
   assign xhold       = w_ctrl.xhold;
   assign xload       = w_ctrl.xload;
   assign yhold       = w_ctrl.yhold;
   assign yload       = w_ctrl.yload;
   assign err         = r_err;
   assign iter_cnt    = r_iter;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: a behavioural model of the GCD datapath closes the loop,
// a scoreboard queue holds expected result/steps/error/arrival cycle per operation.
module tb_gcd_ctrl;
  import gcd_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       x_eq_y;
  logic       x_gt_y;
  logic       xhold;
  logic       xload;
  logic       yhold;
  logic       yload;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;
  logic [7:0] iter_cnt;
  gcd_state_t dbg_state;

  logic [7:0] din;
  logic [7:0] dp_x = 8'd0;
  logic [7:0] dp_y = 8'd0;
  logic [7:0] gcd_rslt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic prev_ov = 1'b0;

  logic [7:0]  exp_res_q[$];
  logic [7:0]  exp_iter_q[$];
  logic [0:0]  exp_err_q[$];
  logic [31:0] exp_t_q[$];

  gcd_ctrl #(.ITER_W(8), .MAX_ITER(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_eq_y     (x_eq_y),
    .x_gt_y     (x_gt_y),
    .xhold      (xhold),
    .xload      (xload),
    .yhold      (yhold),
    .yload      (yload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err),
    .iter_cnt   (iter_cnt),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / datapath model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (xload)       dp_x <= x_gt_y ? dp_x - dp_y : 8'd0;
    else if (!xhold) dp_x <= din;
    if (yload)       dp_y <= (!x_gt_y && !x_eq_y) ? dp_y - dp_x : 8'd0;
    else if (!yhold) dp_y <= din;
  end

  assign x_eq_y   = (dp_x == dp_y);
  assign x_gt_y   = (dp_x > dp_y);
  assign gcd_rslt = dp_x;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // Reference GCD by repeated subtraction with the same step budget.
  task automatic gcd_ref(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [7:0] it, output logic e);
    logic [7:0] x;
    logic [7:0] y;
    int         n;
    x = a; y = b; n = 0; e = 1'b0;
    while (x != y) begin
      if (n == 255) begin
        e = 1'b1;
        break;
      end
      if (x > y) x = x - y;
      else       y = y - x;
      n++;
    end
    r  = x;
    it = 8'(n);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      chk("ld_excl", {30'd0, xload & yload, xload & ~x_gt_y}, 32'd0);
      if (out_valid && !prev_ov) begin
        if (exp_res_q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          chk("latency", 32'(cyc), exp_t_q[0]);
          chk("iter_cnt", 32'(iter_cnt), 32'(exp_iter_q[0]));
          chk("err", 32'(err), 32'(exp_err_q[0]));
          if (!exp_err_q[0]) chk("result", 32'(gcd_rslt), 32'(exp_res_q[0]));
        end
      end
      if (out_valid && out_ready && exp_res_q.size() != 0) begin
        if (!exp_err_q[0]) chk("result_take", 32'(gcd_rslt), 32'(exp_res_q[0]));
        void'(exp_res_q.pop_front());
        void'(exp_iter_q.pop_front());
        void'(exp_err_q.pop_front());
        void'(exp_t_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_operand(input logic [7:0] v, output int t_acc);
    int n;
    bit ok;
    n = 0; ok = 0; t_acc = 0;
    din      = v;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        ok    = 1;
        t_acc = cyc;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!ok) chk("in_ready_wait", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] x, input logic [7:0] y, input int gap,
                           input logic [7:0] res, input logic [7:0] it, input logic e);
    int t_x;
    int t_y;
    drive_operand(x, t_x);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("gap_in_ready", 32'(in_ready), 32'd1);
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_ctrl", {28'd0, xhold, xload, yhold, yload}, 32'b1010);
      chk("gap_x_held", 32'(dp_x), 32'(x));
      @(posedge clk); #1;
    end
    drive_operand(y, t_y);
    exp_res_q.push_back(res);
    exp_iter_q.push_back(it);
    exp_err_q.push_back(e);
    exp_t_q.push_back(32'(t_y + int'(it) + 2));
  endtask

  task automatic send_rand(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic [7:0] it;
    logic       e;
    gcd_ref(x, y, r, it, e);
    send_pair(x, y, 0, r, it, e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_res_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_res_q.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      exp_res_q.delete();
      exp_iter_q.delete();
      exp_err_q.delete();
      exp_t_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int t_dummy;
    reset     = 1'b1;
    in_valid  = 1'b0;
    din       = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctrl", {28'd0, xhold, xload, yhold, yload}, 32'b1010);
    chk("rst_iter", 32'(iter_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // 48,18 -> 6 in 4 steps; din chatter during CALC must be ignored
    send_pair(8'd48, 8'd18, 0, 8'd6, 8'd4, 1'b0);
    in_valid = 1'b1;
    din      = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("calc_in_ready", 32'(in_ready), 32'd0);
      chk("calc_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle(100);

    // equal operands finish without any step
    send_pair(8'd7, 8'd7, 0, 8'd7, 8'd0, 1'b0);
    wait_idle(100);

    // zero against nonzero runs out the budget
    send_pair(8'd0, 8'd5, 0, 8'd5, 8'd255, 1'b1);
    wait_idle(400);

    // zero with zero converges immediately
    send_pair(8'd0, 8'd0, 0, 8'd0, 8'd0, 1'b0);
    wait_idle(100);

    // 255,1 with the consumer stalling for 10 cycles
    out_ready = 1'b0;
    send_pair(8'd255, 8'd1, 0, 8'd1, 8'd254, 1'b0);
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(gcd_rslt), 32'd1);
      chk("stall_iter", 32'(iter_cnt), 32'd254);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(50);

    // 3-cycle gap between operands
    send_pair(8'd12, 8'd8, 3, 8'd4, 8'd2, 1'b0);
    wait_idle(100);

    // reset in the middle of a calculation discards the transaction
    drive_operand(8'd21, t_dummy);
    drive_operand(8'd14, t_dummy);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_iter", 32'(iter_cnt), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(S_LOAD_X));
    @(posedge clk); #1;
    send_pair(8'd9, 8'd6, 0, 8'd3, 8'd2, 1'b0);
    wait_idle(100);

    // random operand pairs against the reference
    for (int k = 0; k < 8; k++) begin
      send_rand(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
      wait_idle(400);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
